// File: rtl/apb_param_pkg.sv
// Shared definitions for the parameterised APB requester.
//   apb_state_t      : requester FSM states (IDLE, SETUP, ACCESS)
//   DEF_*            : default widths / counts used by the top-level parameters
//   TO_CNT_WIDTH     : width of the optional ACCESS wait counter
//   sel_bits()       : number of address MSBs used to pick a completer,
//                      max(1, clog2(num_slaves))
package apb_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_SLAVES  = 4;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int TO_CNT_WIDTH    = 8;

  function automatic int sel_bits(input int num_slaves);
    int b;
    b = $clog2(num_slaves);
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Completer address decoder (purely combinational).
// Ports:
//   addr_msb : the top SEL_BITS bits of the CPU address
//   sel      : one-hot completer select (all-zero on decode error)
//   index    : binary completer index
//   dec_err  : index does not name an existing completer
module apb_addr_decoder
  import apb_param_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int SEL_BITS   = sel_bits(NUM_SLAVES)
) (
  input  logic [SEL_BITS-1:0]   addr_msb,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [SEL_BITS-1:0]   index,
  output logic                  dec_err
);

  always_comb begin
    index   = addr_msb;
    dec_err = (32'(addr_msb) >= 32'(NUM_SLAVES));
    sel     = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (addr_msb == SEL_BITS'(k)) sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_param.sv
// Parameterised APB requester: turns single CPU requests into APB
// SETUP/ACCESS transfers towards one of NUM_SLAVES completers.
// Optional feature macro: APB_MASTER_TIMEOUT_EN (ACCESS wait-cycle abort).
//
// CPU side handshake: a request is taken on any rising edge where
// cpu_valid && cpu_ready; cpu_ready is high only in IDLE, and the requester
// keeps cpu_valid and its payload steady until that edge. cpu_valid seen
// outside IDLE is ignored. Each accepted request (or decode error) yields
// exactly one cpu_done pulse with cpu_err/cpu_rdata valid in that cycle.
//
// Ports:
//   clk, rst                     : clock, async active-high reset
//   cpu_valid/cpu_ready          : request handshake
//   cpu_wr/addr/wdata/strb       : request payload
//   cpu_done/cpu_err/cpu_rdata   : completion pulse and result
//   psel/penable/pwrite/paddr/pwdata/pstrb : APB requester outputs
//   pready/pslverr/prdata        : per-completer APB responses
//   dbg_state                    : current FSM state (apb_state_t encoding)
module apb_master_param
  import apb_param_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_valid,
  output logic                             cpu_ready,
  input  logic                             cpu_wr,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cpu_strb,
  output logic                             cpu_done,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_err,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  output logic [1:0]                       dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_BITS   = sel_bits(NUM_SLAVES);

  // Elaboration-time parameter range checks.
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb_master_param: DATA_WIDTH must be 8, 16 or 32");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
    $error("apb_master_param: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_to
    $error("apb_master_param: TIMEOUT_CYC must be 2..255");
  end

  apb_state_t            state;
  logic [SEL_BITS-1:0]   idx_q;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [SEL_BITS-1:0]   dec_index;
  logic                  dec_err;

  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYC - 1);
  logic [TO_CNT_WIDTH-1:0] to_cnt;
`endif

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .addr_msb (cpu_addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .sel      (dec_sel),
    .index    (dec_index),
    .dec_err  (dec_err)
  );

  // Only the response of the completer latched at accept time is looked at;
  // every other completer's pready/pslverr/prdata is don't-care.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_BITS'(k)) begin
        pready_sel  = pready[k];
        pslverr_sel = pslverr[k];
        prdata_sel  = prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cpu_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            if (dec_err) begin
              // No such completer: answer straight away, bus stays quiet.
              cpu_done  <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              state  <= SETUP;
              idx_q  <= dec_index;
              psel   <= dec_sel;
              paddr  <= cpu_addr;
              pwrite <= cpu_wr;
              pwdata <= cpu_wdata;
              pstrb  <= cpu_wr ? cpu_strb : STRB_WIDTH'(0);
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ACCESS: begin
          // pready is tested first so it wins over a same-cycle timeout.
          if (pready_sel) begin
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= pslverr_sel;
            cpu_rdata <= pwrite ? DATA_WIDTH'(0) : prdata_sel;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state     <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_param.sv
module tb_apb_master_param;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;     // ACCESS cycles with pready low before completion
    logic        slverr;
    logic [31:0] rdata;     // selected completer's read data
    logic [3:0]  exp_psel;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (4 completers) ----------------
  logic           cpu_valid, cpu_ready, cpu_wr, cpu_done, cpu_err;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata, cpu_rdata;
  logic [3:0]     cpu_strb;
  logic [NS-1:0]  psel, pready, pslverr;
  logic           penable, pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [3:0]     pstrb;
  logic [NS*DW-1:0] prdata;
  logic [1:0]     dbg_state;

  apb_master_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_strb(cpu_strb),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (3 completers, always-ready bus) ----------------
  logic           cpu_valid3, cpu_ready3, cpu_wr3, cpu_done3, cpu_err3;
  logic [AW-1:0]  cpu_addr3;
  logic [DW-1:0]  cpu_wdata3, cpu_rdata3;
  logic [3:0]     cpu_strb3;
  logic [2:0]     psel3, pready3, pslverr3;
  logic           penable3, pwrite3;
  logic [AW-1:0]  paddr3;
  logic [DW-1:0]  pwdata3;
  logic [3:0]     pstrb3;
  logic [3*DW-1:0] prdata3;
  logic [1:0]     dbg_state3;

  apb_master_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3), .TIMEOUT_CYC(TO)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid3), .cpu_ready(cpu_ready3), .cpu_wr(cpu_wr3),
    .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3), .cpu_strb(cpu_strb3),
    .cpu_done(cpu_done3), .cpu_rdata(cpu_rdata3), .cpu_err(cpu_err3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .pstrb(pstrb3),
    .pready(pready3), .pslverr(pslverr3), .prdata(prdata3),
    .dbg_state(dbg_state3)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected results come from the bus rules: the two top address bits pick
  // the completer, reads carry no strobes and return the completer's data,
  // writes return zero, the error flag is the completer's pslverr.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   idx;
    r = v;
    idx = int'(v.addr >> 30);
    r.exp_psel  = 4'(1 << idx);
    r.exp_pstrb = v.wr ? v.strb : 4'h0;
    r.exp_rdata = v.wr ? 32'h0 : v.rdata;
    r.exp_err   = v.slverr;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_noise();
    pready  = 4'($urandom);
    pslverr = 4'($urandom);
    prdata  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cpu_garbage();
    cpu_valid = 1'($urandom_range(0, 1));
    cpu_wr    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    cpu_strb  = 4'($urandom);
  endtask

  // Full transfer: starts in IDLE, ends in the completion cycle (still
  // before the next edge) so the caller can chain straight into another.
  task automatic run_xfer(input vec_t v);
    int idx;
    idx = int'(v.addr >> 30);
    check("start_ready", 64'(cpu_ready), 64'd1);
    cpu_valid = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr;
    cpu_wdata = v.wdata; cpu_strb = v.strb;
    bus_noise();
    @(posedge clk); #1;
    // SETUP cycle
    check("setup_psel", 64'(psel), 64'(v.exp_psel));
    check("setup_penable", 64'(penable), 64'd0);
    check("setup_paddr", 64'(paddr), 64'(v.addr));
    check("setup_pwrite", 64'(pwrite), 64'(v.wr));
    check("setup_pwdata", 64'(pwdata), 64'(v.wdata));
    check("setup_pstrb", 64'(pstrb), 64'(v.exp_pstrb));
    check("setup_ready", 64'(cpu_ready), 64'd0);
    cpu_garbage();
    bus_noise();                       // selected pready may be high: SETUP ignores it
    @(posedge clk); #1;
    for (int k = 0; k <= v.waits; k++) begin
      check("access_penable", 64'(penable), 64'd1);
      check("access_psel", 64'(psel), 64'(v.exp_psel));
      check("access_paddr", 64'(paddr), 64'(v.addr));
      check("access_pstrb", 64'(pstrb), 64'(v.exp_pstrb));
      check("access_done", 64'(cpu_done), 64'd0);
      cpu_garbage();
      bus_noise();
      pready[idx] = (k == v.waits);
      if (k == v.waits) begin
        pslverr[idx] = v.slverr;
        prdata[idx*DW +: DW] = v.rdata;
      end
      @(posedge clk); #1;
    end
    cpu_valid = 1'b0;
    check("done_pulse", 64'(cpu_done), 64'd1);
    check("done_err", 64'(cpu_err), 64'(v.exp_err));
    check("done_rdata", 64'(cpu_rdata), 64'(v.exp_rdata));
    check("done_psel", 64'(psel), 64'd0);
    check("done_penable", 64'(penable), 64'd0);
    check("done_ready", 64'(cpu_ready), 64'd1);
  endtask

  task automatic idle_cycle();
    cpu_valid = 1'b0;
    bus_noise();
    @(posedge clk); #1;
    check("idle_done", 64'(cpu_done), 64'd0);
    check("idle_psel", 64'(psel), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t tbl[$];

  initial begin
    vec_t v;
    int   acc_cycles;
    bit   got_done;

    cpu_valid = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_strb = '0;
    pready = '0; pslverr = '0; prdata = '0;
    cpu_valid3 = 0; cpu_wr3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0; cpu_strb3 = '0;
    pready3 = 3'b111; pslverr3 = 3'b000;
    prdata3 = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    // Directed table: {wr, addr, wdata, strb, waits, slverr, rdata, exp...}
    tbl.push_back('{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0, 32'h0,
                    4'b0010, 4'b0011, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h8000_0020, 32'h0, 4'b1111, 3, 1'b0, 32'h1234_5678,
                    4'b0100, 4'b0000, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 32'hC000_0004, 32'h0BAD_F00D, 4'b1010, 1, 1'b1, 32'h0,
                    4'b1000, 4'b1010, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0ABC, 32'h5555_5555, 4'b0101, 2, 1'b1, 32'hCAFE_0001,
                    4'b0001, 4'b0000, 32'hCAFE_0001, 1'b1});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    check("rst_done", 64'(cpu_done), 64'd0);
    check("rst_err", 64'(cpu_err), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_ready", 64'(cpu_ready), 64'd1);
    rst = 1'b0;
    idle_cycle();

    // Directed vectors, separated by an idle cycle
    foreach (tbl[i]) begin
      run_xfer(tbl[i]);
      idle_cycle();
    end

    // Back-to-back: second request presented in the first's cpu_done cycle
    v = '{1'b1, 32'h4000_0100, 32'h1111_2222, 4'hF, 0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0};
    run_xfer(model(v));
    v = '{1'b1, 32'hC000_0200, 32'h3333_4444, 4'h6, 0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0};
    run_xfer(model(v));
    idle_cycle();

    // Randomized transfers against the model, random gaps
    for (int n = 0; n < 24; n++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.waits  = $urandom_range(0, 4);
      v.slverr = ($urandom_range(0, 3) == 0);
      v.rdata  = $urandom;
      run_xfer(model(v));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Reset during ACCESS
    cpu_valid = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h4000_0040;
    cpu_wdata = 32'h7777_8888; cpu_strb = 4'hF;
    pready = '0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid_in_access", 64'(penable), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_psel", 64'(psel), 64'd0);
    check("rstmid_penable", 64'(penable), 64'd0);
    check("rstmid_ready", 64'(cpu_ready), 64'd1);
    @(posedge clk); #1;
    check("rstmid_nodone", 64'(cpu_done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_nodone2", 64'(cpu_done), 64'd0);
    check("rstmid_ready2", 64'(cpu_ready), 64'd1);
    v = '{1'b0, 32'h4000_0044, 32'h0, 4'hF, 1, 1'b0, 32'h2468_ACE0, 4'h0, 4'h0, 32'h0, 1'b0};
    run_xfer(model(v));
    idle_cycle();

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never ready: abort after TO ACCESS cycles
    cpu_valid = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0010;
    cpu_wdata = '0; cpu_strb = '0;
    pready = '0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    acc_cycles = 0; got_done = 1'b0;
    for (int c = 0; c < 3 * TO; c++) begin
      pready = '0;
      @(posedge clk); #1;
      if (cpu_done) begin
        got_done = 1'b1;
        break;
      end
      if (penable) acc_cycles++;
    end
    check("to_done_seen", 64'(got_done), 64'd1);
    check("to_access_cycles", 64'(acc_cycles), 64'(TO));
    check("to_err", 64'(cpu_err), 64'd1);
    check("to_rdata", 64'(cpu_rdata), 64'd0);
    idle_cycle();
    // pready on the last allowed ACCESS cycle wins
    v = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, TO - 1, 1'b0, 32'h600D_600D, 4'h0, 4'h0, 32'h0, 1'b0};
    run_xfer(model(v));
    idle_cycle();
`else
    // No timeout: a long wait still completes normally
    acc_cycles = 0; got_done = 1'b0;
    v = '{1'b0, 32'hC000_0030, 32'h0, 4'h3, TO + 4, 1'b0, 32'h0F0F_1234, 4'h0, 4'h0, 32'h0, 1'b0};
    run_xfer(model(v));
    idle_cycle();
`endif

    // Three-completer instance: undecodable index and a normal read
    cpu_valid3 = 1'b1; cpu_wr3 = 1'b1; cpu_addr3 = 32'hC000_0000;
    cpu_wdata3 = 32'hFFFF_FFFF; cpu_strb3 = 4'hF;
    @(posedge clk); #1;
    cpu_valid3 = 1'b0;
    check("dec_done", 64'(cpu_done3), 64'd1);
    check("dec_err", 64'(cpu_err3), 64'd1);
    check("dec_rdata", 64'(cpu_rdata3), 64'd0);
    check("dec_psel", 64'(psel3), 64'd0);
    check("dec_ready", 64'(cpu_ready3), 64'd1);
    @(posedge clk); #1;
    check("dec_done_once", 64'(cpu_done3), 64'd0);
    check("dec_psel_quiet", 64'(psel3), 64'd0);
    cpu_valid3 = 1'b1; cpu_wr3 = 1'b0; cpu_addr3 = 32'h8000_0008;
    @(posedge clk); #1;
    cpu_valid3 = 1'b0;
    check("s3_setup_psel", 64'(psel3), 64'b100);
    @(posedge clk); #1;
    check("s3_access_penable", 64'(penable3), 64'd1);
    @(posedge clk); #1;
    check("s3_done", 64'(cpu_done3), 64'd1);
    check("s3_err", 64'(cpu_err3), 64'd0);
    check("s3_rdata", 64'(cpu_rdata3), 64'hA5A5_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
